// File: rtl/bp_mc_req_arbiter.sv
// bp_mc_req_arbiter
//   Shares one manycore endpoint out-request port between num_req_p request
//   sources. It picks a winner round-robin and tracks endpoint out-credits.
//   It holds one registered output packet. A drain FSM stops new grants and
//   waits until every credit has come back.
//
// Ports
//   clk_i              clock
//   reset_i            synchronous active-high reset
//   req_v_i            per-source request valid
//   req_packet_i       per-source packets, source i at [i*packet_width_p +: packet_width_p]
//   req_yumi_o         one-hot dequeue to the granted source (combinational)
//   out_v_o            registered packet valid toward the endpoint
//   out_packet_o       registered packet toward the endpoint
//   out_ready_i        endpoint accepts when out_v_o & out_ready_i
//   credit_return_v_i  one credit returned this cycle
//   drain_i            stop new grants and wait for all credits
//   drained_o          drain complete
//   credits_o          currently available credits
module bp_mc_req_arbiter #(
  parameter int num_req_p       = 2,
  // There is no meaningful default packet width. Instantiators are expected to set it.
  parameter int packet_width_p  = 32,
  parameter int max_credits_p   = 15,
  localparam int credit_width_lp = $clog2(max_credits_p + 1)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p-1:0]                req_v_i,
  input  logic [num_req_p*packet_width_p-1:0] req_packet_i,
  output logic [num_req_p-1:0]                req_yumi_o,
  output logic                                out_v_o,
  output logic [packet_width_p-1:0]           out_packet_o,
  input  logic                                out_ready_i,
  input  logic                                credit_return_v_i,
  input  logic                                drain_i,
  output logic                                drained_o,
  output logic [credit_width_lp-1:0]          credits_o
);

  localparam int idx_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_credits_p);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAINING = 2'd1,
    DRAINED  = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [credit_width_lp-1:0]  credits_q, credits_d;
  logic [idx_width_lp-1:0]     last_q, last_d;
  logic                        out_v_q, out_v_d;
  logic [packet_width_p-1:0]   out_packet_q, out_packet_d;

  logic                        winner_found;
  logic [idx_width_lp-1:0]     winner_idx;
  int                          cand;
  logic                        grant;

  // Round-robin search. It starts one past the last winner and wraps.
  // The first valid source found is the winner.
  always_comb begin
    winner_found = 1'b0;
    winner_idx   = '0;
    cand         = 0;
    for (int off = 1; off <= num_req_p; off++) begin
      cand = (int'(last_q) + off) % num_req_p;
      if (!winner_found && req_v_i[cand]) begin
        winner_found = 1'b1;
        winner_idx   = idx_width_lp'(cand);
      end
    end
  end

  // A grant needs four things: a request, a credit, a free output slot, and the
  // IDLE state. The slot is free if it is empty now or is being accepted this
  // cycle. Reset suppresses the grant so that no yumi leaks out.
  assign grant = !reset_i && winner_found && (credits_q != '0)
              && (!out_v_q || out_ready_i) && (state_q == IDLE);

  assign req_yumi_o = grant ? (num_req_p'(1) << winner_idx) : '0;

  always_comb begin
    last_d       = last_q;
    out_v_d      = out_v_q;
    out_packet_d = out_packet_q;
    credits_d    = credits_q;

    if (grant) begin
      last_d       = winner_idx;
      out_v_d      = 1'b1;
      out_packet_d = req_packet_i[int'(winner_idx)*packet_width_p +: packet_width_p];
    end else if (out_ready_i) begin
      out_v_d      = 1'b0;
    end

    // A return that arrives when credits are already full (with no grant) saturates.
    unique case ({grant, credit_return_v_i})
      2'b10:   credits_d = credits_q - credit_width_lp'(1);
      2'b01:   credits_d = (credits_q == max_credits_lp) ? credits_q
                                                         : credits_q + credit_width_lp'(1);
      default: credits_d = credits_q;
    endcase
  end

  // Drain FSM. DRAINING checks the values the registers will hold next cycle.
  // That lets drained_o rise in the cycle right after the final credit return.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (drain_i) state_d = DRAINING;
      DRAINING: begin
        if (!drain_i)                                       state_d = IDLE;
        else if (credits_d == max_credits_lp && !out_v_d)   state_d = DRAINED;
      end
      DRAINED:  if (!drain_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      credits_q    <= max_credits_lp;
      last_q       <= idx_width_lp'(num_req_p - 1);
      out_v_q      <= 1'b0;
      out_packet_q <= '0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      last_q       <= last_d;
      out_v_q      <= out_v_d;
      out_packet_q <= out_packet_d;
    end
  end

  assign out_v_o      = out_v_q;
  assign out_packet_o = out_packet_q;
  assign credits_o    = credits_q;
  assign drained_o    = !reset_i && (state_q == DRAINED);

`ifndef SYNTHESIS
  // A credit returned while all credits are already home means the endpoint
  // and this block disagree about how many packets are in flight.
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(credit_return_v_i && !grant && credits_q == max_credits_lp))
        else $error("bp_mc_req_arbiter: credit return overflow");
    end
  end
`endif

endmodule
